// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memunit arbiter: sequencer states, port indices
// and the default watchdog limit.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ISSUE       = 3'd1,
    WAIT_ACCEPT = 3'd2,
    WAIT_DONE   = 3'd3,
    DONE        = 3'd4
  } arb_state_t;

  localparam logic PORT_D = 1'b0;
  localparam logic PORT_I = 1'b1;

  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between the data port and the fetch port.
// Build option MEM_ARB_RR_EN: round-robin on ties; otherwise port 0 has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_idx
);

  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = PORT_D;
    if (req0 && req1) begin
`ifdef MEM_ARB_RR_EN
      grant_idx = ~last_grant;
`else
      grant_idx = PORT_D;
`endif
    end else if (req1) begin
      grant_idx = PORT_I;
    end
  end

`ifndef MEM_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of memunit with read capture and a watchdog.
// Build option MEM_ARB_RR_EN selects round-robin tie breaking (see mem_arb_pick).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  p0_req,
  input  logic                  p1_req,
  input  logic                  p0_rwn,
  input  logic                  p1_rwn,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p0_done,
  output logic                  p1_done,
  output logic                  p0_err,
  output logic                  p1_err,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  owner,
  output logic                  busy,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  mem_data_valid,
  output logic                  mem_enable,
  output logic                  mem_rwn,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in
);

  // The counter starts at 0 in the first wait cycle, so the abort fires on its last value.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  arb_state_t            state, state_next;
  logic [7:0]            wait_count;
  logic                  timed_out;
  logic                  valid_seen, valid_seen_next;
  logic                  last_grant;
  logic [DATA_WIDTH-1:0] staging, staging_next;
  logic                  grant_valid, grant_idx;
  logic                  grant_fire, count_hit, timeout_fire, capture, enter_done;
  logic                  done_err;

  mem_arb_pick u_pick (
    .req0        (p0_req),
    .req1        (p1_req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    state_next   = state;
    grant_fire   = 1'b0;
    timeout_fire = 1'b0;
    count_hit    = (wait_count == TIMEOUT_LAST);
    capture      = (state == WAIT_DONE) && mem_rwn && mem_data_valid;
    case (state)
      IDLE: begin
        if (mem_ready && grant_valid) begin
          state_next = ISSUE;
          grant_fire = 1'b1;
        end
      end
      ISSUE: state_next = WAIT_ACCEPT;
      WAIT_ACCEPT: begin
        if (count_hit) begin
          timeout_fire = 1'b1;
          state_next   = DONE;
        end else if (!mem_ready) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (mem_ready) begin
          state_next = DONE;
        end else if (count_hit) begin
          timeout_fire = 1'b1;
          state_next   = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    staging_next    = capture ? mem_data_out : staging;
    valid_seen_next = (state == ISSUE) ? 1'b0 : (valid_seen | capture);
    enter_done      = (state_next == DONE) && (state != DONE);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state       <= IDLE;
      wait_count  <= 8'd0;
      timed_out   <= 1'b0;
      valid_seen  <= 1'b0;
      last_grant  <= 1'b1;
      staging     <= '0;
      owner       <= PORT_D;
      mem_enable  <= 1'b0;
      mem_rwn     <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      p0_rdata    <= '0;
      p1_rdata    <= '0;
    end else begin
      state      <= state_next;
      staging    <= staging_next;
      valid_seen <= valid_seen_next;
      mem_enable <= grant_fire;
      if (grant_fire) begin
        owner      <= grant_idx;
        last_grant <= grant_idx;
        if (grant_idx == PORT_I) begin
          mem_rwn     <= p1_rwn;
          mem_addr    <= p1_addr;
          mem_data_in <= p1_wdata;
        end else begin
          mem_rwn     <= p0_rwn;
          mem_addr    <= p0_addr;
          mem_data_in <= p0_wdata;
        end
      end
      if (state == ISSUE) begin
        wait_count <= 8'd0;
        timed_out  <= 1'b0;
      end else if (state == WAIT_ACCEPT || state == WAIT_DONE) begin
        wait_count <= wait_count + 8'd1;
        if (timeout_fire) timed_out <= 1'b1;
      end
      // rdata is written on the edge into DONE so it is already valid alongside the done pulse.
      if (enter_done && mem_rwn) begin
        if (owner == PORT_I) p1_rdata <= staging_next;
        else                 p0_rdata <= staging_next;
      end
    end
  end

  assign busy     = (state != IDLE);
  assign done_err = timed_out || (mem_rwn && !valid_seen);
  assign p0_done  = (state == DONE) && (owner == PORT_D);
  assign p1_done  = (state == DONE) && (owner == PORT_I);
  assign p0_err   = p0_done && done_err;
  assign p1_err   = p1_done && done_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memunit model plus a transaction-level
// reference for grant order, error flags, read staging and per-port rdata.
module tb_mem_arbiter;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        p0_req = 1'b0, p1_req = 1'b0, p0_rwn = 1'b0, p1_rwn = 1'b0;
  logic [15:0] p0_addr = '0, p1_addr = '0, p0_wdata = '0, p1_wdata = '0;
  logic        p0_done, p1_done, p0_err, p1_err, owner, busy;
  logic [15:0] p0_rdata, p1_rdata;
  logic        mem_ready = 1'b1, mem_data_valid = 1'b0;
  logic [15:0] mem_data_out = '0;
  logic        mem_enable, mem_rwn;
  logic [15:0] mem_addr, mem_data_in;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // memunit model controls and state
  int          model_busy = 4;
  int          model_nbeats = 0;
  bit          model_hang = 1'b0;
  int          model_left = 0;
  logic [15:0] beat_data [2];

  // reference model state
  logic [15:0] exp_rdata [2];
  logic [15:0] exp_staging;
  int          model_last;

  // observations from the last run_op
  int          ob_en_count, ob_issue_cyc, ob_done_cyc, ob_req_lat;
  logic [15:0] ob_en_addr, ob_en_data, ob_rdata0, ob_rdata1;
  logic        ob_en_rwn, ob_done_port, ob_done_both, ob_err, ob_done_after, ob_busy_issue;
  bit          ob_expired;

  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT(TO)) dut (
    .clk(clk), .nrst(nrst),
    .p0_req(p0_req), .p1_req(p1_req), .p0_rwn(p0_rwn), .p1_rwn(p1_rwn),
    .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_done(p0_done), .p1_done(p1_done), .p0_err(p0_err), .p1_err(p1_err),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata), .owner(owner), .busy(busy),
    .mem_ready(mem_ready), .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
    .mem_enable(mem_enable), .mem_rwn(mem_rwn), .mem_addr(mem_addr), .mem_data_in(mem_data_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // memunit: drops ready after a start strobe, optional valid beats at the end of the busy window
  always @(negedge clk) begin
    mem_data_valid = 1'b0;
    if (mem_enable) begin
      mem_ready  = 1'b0;
      model_left = model_busy;
    end else if (!mem_ready) begin
      if (model_left > 0) model_left--;
      if (model_left == 0 && !model_hang) begin
        mem_ready = 1'b1;
      end else if (model_left > 0 && model_left <= model_nbeats) begin
        mem_data_valid = 1'b1;
        mem_data_out   = beat_data[model_nbeats - model_left];
      end
    end
  end

  task automatic run_op(input logic port, input logic rwn, input logic [15:0] addr,
                        input logic [15:0] wdata, input int bsy, input int nbeats,
                        input bit hang, input logic [15:0] b0, input logic [15:0] b1);
    int req_cyc;
    model_busy   = bsy;
    model_nbeats = nbeats;
    model_hang   = hang;
    beat_data[0] = b0;
    beat_data[1] = b1;
    ob_en_count  = 0;
    ob_expired   = 1'b1;
    ob_issue_cyc = 0;
    @(negedge clk);
    if (port) begin
      p1_req = 1'b1; p1_rwn = rwn; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_req = 1'b1; p0_rwn = rwn; p0_addr = addr; p0_wdata = wdata;
    end
    req_cyc = cyc;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_enable) begin
        ob_en_count++;
        ob_issue_cyc  = cyc;
        ob_en_addr    = mem_addr;
        ob_en_data    = mem_data_in;
        ob_en_rwn     = mem_rwn;
        ob_busy_issue = busy;
      end
      if (p0_done || p1_done) begin
        ob_expired   = 1'b0;
        ob_done_port = p1_done;
        ob_done_both = p0_done & p1_done;
        ob_err       = p1_done ? p1_err : p0_err;
        ob_rdata0    = p0_rdata;
        ob_rdata1    = p1_rdata;
        ob_done_cyc  = cyc;
        break;
      end
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    @(negedge clk);
    ob_done_after = p0_done | p1_done;
    ob_req_lat    = ob_issue_cyc - req_cyc;
    if (ob_en_count > 0) model_last = int'(port);
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    p0_req = 1'b0;
    p1_req = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({mem_enable, mem_rwn, busy, owner, p0_done, p1_done, p0_err, p1_err} !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_ctrl: got %b want 00000000",
               {mem_enable, mem_rwn, busy, owner, p0_done, p1_done, p0_err, p1_err});
    end
    total++;
    if ({mem_addr, mem_data_in} !== 32'h0) begin
      bad++; $display("[TB] FAIL reset_mem_bus: got %h want 0", {mem_addr, mem_data_in});
    end
    total++;
    if ({p0_rdata, p1_rdata} !== 32'h0) begin
      bad++; $display("[TB] FAIL reset_rdata: got %h want 0", {p0_rdata, p1_rdata});
    end
    nrst = 1'b1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    exp_staging  = '0;
    model_last   = 1;
  endtask

  task automatic test_single_write;
    run_op(1'b0, 1'b0, 16'h1234, 16'hBEEF, 6, 0, 1'b0, 16'h0, 16'h0);
    total++; if (ob_expired !== 1'b0) begin bad++; $display("[TB] FAIL wr_done_seen: got expired want done"); end
    total++; if (ob_en_count !== 1) begin bad++; $display("[TB] FAIL wr_enable_count: got %0d want 1", ob_en_count); end
    total++; if (ob_en_addr !== 16'h1234) begin bad++; $display("[TB] FAIL wr_addr: got %h want 1234", ob_en_addr); end
    total++; if (ob_en_data !== 16'hBEEF) begin bad++; $display("[TB] FAIL wr_data: got %h want beef", ob_en_data); end
    total++; if (ob_en_rwn !== 1'b0) begin bad++; $display("[TB] FAIL wr_rwn: got %b want 0", ob_en_rwn); end
    total++; if (ob_busy_issue !== 1'b1) begin bad++; $display("[TB] FAIL wr_busy_at_issue: got %b want 1", ob_busy_issue); end
    total++; if (ob_done_port !== 1'b0 || ob_done_both !== 1'b0) begin
      bad++; $display("[TB] FAIL wr_done_port: got p1_done=%b both=%b want 0 0", ob_done_port, ob_done_both); end
    total++; if (ob_err !== 1'b0) begin bad++; $display("[TB] FAIL wr_err: got %b want 0", ob_err); end
    total++; if (ob_req_lat !== 1) begin bad++; $display("[TB] FAIL wr_issue_latency: got %0d want 1", ob_req_lat); end
    total++; if (ob_done_cyc - ob_issue_cyc !== 7) begin
      bad++; $display("[TB] FAIL wr_done_latency: got %0d want 7", ob_done_cyc - ob_issue_cyc); end
    total++; if (ob_done_after !== 1'b0) begin bad++; $display("[TB] FAIL wr_done_one_cycle: got %b want 0", ob_done_after); end
  endtask

  task automatic test_single_read;
    run_op(1'b1, 1'b1, 16'h0040, 16'h0, 5, 1, 1'b0, 16'hA5A5, 16'h0);
    exp_staging  = 16'hA5A5;
    exp_rdata[1] = exp_staging;
    total++; if (ob_expired !== 1'b0 || ob_done_port !== 1'b1) begin
      bad++; $display("[TB] FAIL rd_done_port: got expired=%b port=%b want 0 1", ob_expired, ob_done_port); end
    total++; if (ob_en_addr !== 16'h0040 || ob_en_rwn !== 1'b1) begin
      bad++; $display("[TB] FAIL rd_issue: got addr=%h rwn=%b want 0040 1", ob_en_addr, ob_en_rwn); end
    total++; if (ob_rdata1 !== exp_rdata[1]) begin bad++; $display("[TB] FAIL rd_p1_rdata: got %h want %h", ob_rdata1, exp_rdata[1]); end
    total++; if (ob_rdata0 !== exp_rdata[0]) begin bad++; $display("[TB] FAIL rd_p0_rdata: got %h want %h", ob_rdata0, exp_rdata[0]); end
    total++; if (ob_err !== 1'b0) begin bad++; $display("[TB] FAIL rd_err: got %b want 0", ob_err); end
  endtask

  task automatic test_random_ops;
    for (int n = 0; n < 16; n++) begin
      logic        port, rwn, exp_err;
      logic [15:0] addr, wdata;
      int          bsy, nb;
      port  = 1'($urandom_range(0, 1));
      rwn   = 1'($urandom_range(0, 1));
      addr  = 16'($urandom);
      wdata = 16'($urandom);
      bsy   = $urandom_range(4, 8);
      nb    = $urandom_range(0, 2);
      run_op(port, rwn, addr, wdata, bsy, nb, 1'b0, 16'($urandom), 16'($urandom));
      if (rwn) begin
        if (nb > 0) exp_staging = beat_data[nb - 1];
        exp_rdata[port] = exp_staging;
      end
      exp_err = rwn && (nb == 0);
      total++; if (ob_expired !== 1'b0 || ob_done_port !== port || ob_done_both !== 1'b0) begin
        bad++; $display("[TB] FAIL rnd%0d_done_port: got expired=%b port=%b want port %b", n, ob_expired, ob_done_port, port); end
      total++; if (ob_en_count !== 1 || ob_en_addr !== addr || ob_en_data !== wdata || ob_en_rwn !== rwn) begin
        bad++; $display("[TB] FAIL rnd%0d_issue: got n=%0d %h %h %b want 1 %h %h %b", n,
                        ob_en_count, ob_en_addr, ob_en_data, ob_en_rwn, addr, wdata, rwn); end
      total++; if (ob_err !== exp_err) begin bad++; $display("[TB] FAIL rnd%0d_err: got %b want %b", n, ob_err, exp_err); end
      total++; if (ob_rdata0 !== exp_rdata[0] || ob_rdata1 !== exp_rdata[1]) begin
        bad++; $display("[TB] FAIL rnd%0d_rdata: got %h %h want %h %h", n, ob_rdata0, ob_rdata1, exp_rdata[0], exp_rdata[1]); end
      total++; if (ob_done_cyc - ob_issue_cyc !== bsy + 1) begin
        bad++; $display("[TB] FAIL rnd%0d_latency: got %0d want %0d", n, ob_done_cyc - ob_issue_cyc, bsy + 1); end
    end
  endtask

  task automatic test_back_to_back;
    int exp_order[$];
    int got_order[$];
    int rem[2];
    int last, g, prev_done, extra;
    rem[0] = 3; rem[1] = 3;
    last = model_last;
    while (rem[0] + rem[1] > 0) begin
      if (rem[0] > 0 && rem[1] > 0) begin
`ifdef MEM_ARB_RR_EN
        g = 1 - last;
`else
        g = 0;
`endif
      end else begin
        g = (rem[0] > 0) ? 0 : 1;
      end
      exp_order.push_back(g);
      rem[g]--;
      last = g;
    end
    model_busy = 4; model_nbeats = 0; model_hang = 1'b0;
    rem[0] = 3; rem[1] = 3;
    prev_done = -1;
    @(negedge clk);
    p0_req = 1'b1; p0_rwn = 1'b0; p0_addr = 16'h1000; p0_wdata = 16'h1111;
    p1_req = 1'b1; p1_rwn = 1'b0; p1_addr = 16'h2000; p1_wdata = 16'h2222;
    for (int i = 0; i < 300 && (rem[0] + rem[1] > 0); i++) begin
      @(negedge clk);
      if (mem_enable) begin
        got_order.push_back((mem_addr == 16'h2000) ? 1 : 0);
        if (prev_done >= 0) begin
          total++; if (cyc !== prev_done + 2) begin
            bad++; $display("[TB] FAIL b2b_gap: got issue at +%0d want +2", cyc - prev_done); end
        end
      end
      if (p0_done) begin rem[0]--; prev_done = cyc; if (rem[0] == 0) p0_req = 1'b0; end
      if (p1_done) begin rem[1]--; prev_done = cyc; if (rem[1] == 0) p1_req = 1'b0; end
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    extra = 0;
    repeat (6) begin @(negedge clk); if (mem_enable) extra++; end
    total++; if (got_order.size() !== 6 || extra !== 0) begin
      bad++; $display("[TB] FAIL b2b_grant_count: got %0d extra=%0d want 6 0", got_order.size(), extra); end
    for (int k = 0; k < 6 && k < got_order.size(); k++) begin
      total++; if (got_order[k] !== exp_order[k]) begin
        bad++; $display("[TB] FAIL b2b_order[%0d]: got %0d want %0d", k, got_order[k], exp_order[k]); end
    end
    model_last = exp_order[5];
  endtask

  task automatic test_timeout;
    int  n_en;
    bit  got;
    logic err;
    run_op(1'b0, 1'b1, 16'h0BAD, 16'h0, 4, 0, 1'b1, 16'h0, 16'h0);
    exp_rdata[0] = exp_staging;
    total++; if (ob_expired !== 1'b0 || ob_done_port !== 1'b0) begin
      bad++; $display("[TB] FAIL to_done: got expired=%b port=%b want 0 0", ob_expired, ob_done_port); end
    total++; if (ob_err !== 1'b1) begin bad++; $display("[TB] FAIL to_err: got %b want 1", ob_err); end
    total++; if (ob_done_cyc - ob_issue_cyc !== TO + 1) begin
      bad++; $display("[TB] FAIL to_latency: got %0d want %0d", ob_done_cyc - ob_issue_cyc, TO + 1); end
    total++; if (ob_rdata0 !== exp_rdata[0]) begin bad++; $display("[TB] FAIL to_rdata: got %h want %h", ob_rdata0, exp_rdata[0]); end
    p1_req = 1'b1; p1_rwn = 1'b0; p1_addr = 16'h5555; p1_wdata = 16'($urandom);
    model_busy = 4;
    n_en = 0;
    repeat (10) begin @(negedge clk); if (mem_enable) n_en++; end
    total++; if (n_en !== 0 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL to_hold_off: got enables=%0d busy=%b want 0 0", n_en, busy); end
    model_hang = 1'b0;
    got = 1'b0;
    err = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_enable) n_en++;
      if (p1_done) begin got = 1'b1; err = p1_err; break; end
    end
    p1_req = 1'b0;
    model_last = 1;
    total++; if (got !== 1'b1 || n_en !== 1 || err !== 1'b0) begin
      bad++; $display("[TB] FAIL to_recover: got done=%b enables=%0d err=%b want 1 1 0", got, n_en, err); end
  endtask

  task automatic test_reset_midop;
    bit seen;
    int n_done, n_en;
    model_busy = 8; model_nbeats = 1; model_hang = 1'b0; beat_data[0] = 16'h7E57;
    @(negedge clk);
    p0_req = 1'b1; p0_rwn = 1'b1; p0_addr = 16'h0777;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_enable) begin seen = 1'b1; break; end
    end
    total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL mid_issue: got no enable want enable"); end
    repeat (3) @(negedge clk);
    nrst = 1'b0;
    p0_req = 1'b0;
    @(negedge clk);
    total++;
    if ({mem_enable, mem_rwn, busy, owner, p0_done, p1_done, p0_err, p1_err} !== 8'h00) begin
      bad++;
      $display("[TB] FAIL mid_reset_ctrl: got %b want 00000000",
               {mem_enable, mem_rwn, busy, owner, p0_done, p1_done, p0_err, p1_err});
    end
    total++;
    if ({mem_addr, mem_data_in, p0_rdata, p1_rdata} !== 64'h0) begin
      bad++; $display("[TB] FAIL mid_reset_data: got %h want 0", {mem_addr, mem_data_in, p0_rdata, p1_rdata});
    end
    nrst = 1'b1;
    exp_rdata[0] = '0; exp_rdata[1] = '0; exp_staging = '0; model_last = 1;
    n_done = 0; n_en = 0;
    repeat (15) begin
      @(negedge clk);
      if (p0_done || p1_done) n_done++;
      if (mem_enable) n_en++;
    end
    total++; if (n_done !== 0 || n_en !== 0) begin
      bad++; $display("[TB] FAIL mid_no_done: got done=%0d enables=%0d want 0 0", n_done, n_en); end
    run_op(1'b0, 1'b0, 16'h3C3C, 16'h4D4D, 5, 1, 1'b0, 16'h9999, 16'h0);
    total++; if (ob_expired !== 1'b0 || ob_en_count !== 1 || ob_en_addr !== 16'h3C3C || ob_err !== 1'b0) begin
      bad++; $display("[TB] FAIL mid_fresh_op: got expired=%b n=%0d addr=%h err=%b want 0 1 3c3c 0",
                      ob_expired, ob_en_count, ob_en_addr, ob_err); end
    total++; if (ob_rdata0 !== exp_rdata[0]) begin bad++; $display("[TB] FAIL mid_write_rdata: got %h want %h", ob_rdata0, exp_rdata[0]); end
  endtask

  task automatic test_no_valid_read;
    run_op(1'b1, 1'b1, 16'h0ABC, 16'h0, 5, 0, 1'b0, 16'h1357, 16'h0);
    exp_rdata[1] = exp_staging;
    total++; if (ob_expired !== 1'b0 || ob_done_port !== 1'b1) begin
      bad++; $display("[TB] FAIL nv_done: got expired=%b port=%b want 0 1", ob_expired, ob_done_port); end
    total++; if (ob_err !== 1'b1) begin bad++; $display("[TB] FAIL nv_err: got %b want 1", ob_err); end
    total++; if (ob_rdata1 !== exp_rdata[1]) begin bad++; $display("[TB] FAIL nv_rdata: got %h want %h", ob_rdata1, exp_rdata[1]); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_random_ops();
    test_back_to_back();
    test_timeout();
    test_reset_midop();
    test_no_valid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
